bus_arbiter4: RTL and testbench
===============================

BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter: MAX_BURST, default 8; maximum accepted beats per grant, legal range 1..255.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  4  request per source 0..3; bit i set means source i has a beat to send.
REQ-005 Port: ready  input  1  consumer accepts the current beat this cycle.
REQ-006 Port: gnt  output  4  registered one-hot grant; all zero when no owner.
REQ-007 Port: sel  output  2  registered binary index of owner; drives the 4:1 data mux select.
REQ-008 Port: valid  output  1  owner present and its req bit set this cycle.
REQ-009 Port: beat_cnt  output  8  registered beats accepted in the current grant.

Function
REQ-010 State machine SHALL have two states: IDLE (no owner) and OWN (one owner, index = sel).
REQ-011 Round-robin pointer ptr[1:0] SHALL set search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set req bit in that order wins.
REQ-012 IDLE: if req != 0, next edge SHALL enter OWN with gnt = one-hot(winner), sel = winner, beat_cnt = 0; else remain IDLE.
REQ-013 Grant latency SHALL be exactly one cycle from req sampled in IDLE to gnt asserted.
REQ-014 valid SHALL equal (state == OWN) AND req[sel], combinationally from registered state and the req input.
REQ-015 A beat SHALL occur in a cycle where valid = 1 and ready = 1; each beat increments beat_cnt by 1.
REQ-016 Release SHALL occur in OWN when req[sel] = 0 (no beat that cycle), or when a beat occurs with beat_cnt == MAX_BURST-1.
REQ-017 On release, ptr SHALL load sel+1 mod 4 (3 wraps to 0), and arbitration SHALL be re-run that same cycle using the new ptr and the current req.
REQ-018 If the release-cycle arbitration finds a winner, the next edge SHALL enter OWN with the new gnt/sel and beat_cnt = 0 (no IDLE bubble); otherwise the next edge SHALL enter IDLE.
REQ-019 The released owner SHALL be re-grantable in the release-cycle arbitration only when no other req bit is set.
REQ-020 ready = 0 in OWN SHALL hold gnt, sel and beat_cnt unchanged; stalls have no time limit.
REQ-021 ready SHALL be ignored in IDLE.
REQ-022 In IDLE, gnt SHALL be 4'b0000, valid SHALL be 0, and sel SHALL hold its last value.
REQ-023 gnt SHALL never have more than one bit set.
REQ-024 Requests from non-owners SHALL NOT affect an in-progress grant.
REQ-025 With MAX_BURST = 1, every beat SHALL release the grant.

Reset
REQ-026 rst = 1 at a rising edge SHALL force state IDLE, gnt = 0, sel = 0, ptr = 0, beat_cnt = 0, and hence valid = 0.
REQ-027 Reset SHALL override all other activity, including mid-burst; the in-flight grant is discarded and no beat is counted in that cycle.
REQ-028 The first arbitration after reset deasserts SHALL use ptr = 0.

Verification
REQ-029 MAX_BURST = 4, req = 0001, ready = 1 -> gnt = 0001, sel = 0 one cycle later; beat_cnt 0,1,2,3; the grant is then re-issued to 0001 with beat_cnt = 0 and no idle cycle.
REQ-030 MAX_BURST = 2, req = 1111, ready = 1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 with 2 beats each; sel sequence 0, 1, 2, 3, 0.
REQ-031 Owner 1 granted, ready = 0 for 10 cycles -> gnt = 0010, valid = 1, beat_cnt frozen; ready = 1 resumes counting from the frozen value.
REQ-032 Owner 2 drops req after 1 beat while req[3] = 1 -> next edge gnt = 1000, sel = 3, beat_cnt = 0; after owner 3 releases, ptr = 0.
REQ-033 rst pulsed mid-burst of owner 3 -> next edge gnt = 0, sel = 0, beat_cnt = 0; then req = 1010 -> gnt = 0010.
REQ-034 Integration: sel drives a 4:1 mux with inputs 11111111/22222222/33333333/44444444 -> mux output equals the owner's word on every beat of REQ-030.

Source files
------------

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-source round-robin bus arbiter with a per-grant burst limit.
// The owner keeps the bus until it drops req or completes MAX_BURST beats.
module bus_arbiter4 #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ready,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic [7:0] beat_cnt
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;
    localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] arb_ptr, off, win;
    logic [3:0] rot;
    logic       owned, beat, rel, arb, found;

    always_comb begin
        owned   = state_q == OWN;
        valid   = owned && req[sel_q];
        beat    = valid && ready;
        rel     = owned && (!req[sel_q] || (beat && cnt_q == LAST));
        // On release the search starts just past the old owner, in the same cycle.
        arb_ptr = rel ? sel_q + 2'd1 : ptr_q;
        rot     = {req[arb_ptr + 2'd3], req[arb_ptr + 2'd2], req[arb_ptr + 2'd1], req[arb_ptr]};
        found   = |rot;
        off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        win     = arb_ptr + off;
        arb     = !owned || rel;
        ptr_d   = arb_ptr;
        state_d = arb ? (found ? OWN : IDLE) : state_q;
        gnt_d   = arb ? (found ? 4'b0001 << win : 4'b0000) : gnt_q;
        sel_d   = arb && found ? win : sel_q;
        cnt_d   = arb ? 8'd0 : cnt_q + {7'd0, beat};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign beat_cnt = cnt_q;
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: three arbiters (MAX_BURST 1, 2, 4) on shared inputs, checked
// every cycle against a rule-level model plus directed scenarios.
module tb_bus_arbiter4;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;
    logic [3:0] gnt [3];
    logic [1:0] sel [3];
    logic       valid [3];
    logic [7:0] beat_cnt [3];
    logic [31:0] mux_word [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_arbiter4 #(.MAX_BURST(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clk(clk), .rst(rst), .req(req), .ready(ready),
            .gnt(gnt[g]), .sel(sel[g]), .valid(valid[g]), .beat_cnt(beat_cnt[g])
        );
        assign mux_word[g] = sel[g] == 2'd0 ? 32'h11111111 : sel[g] == 2'd1 ? 32'h22222222 :
                             sel[g] == 2'd2 ? 32'h33333333 : 32'h44444444;
    end

    int checks = 0;
    int failures = 0;
    int mb [3] = '{1, 2, 4};
    bit own [3];
    int owner [3];
    int ptr [3];
    int cnt [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic cycle(input logic [3:0] r, input logic rd, input logic rs);
        int w;
        bit bt;
        @(negedge clk);
        req = r;
        ready = rd;
        rst = rs;
        #1;
        for (int m = 0; m < 3; m++) begin
            check($sformatf("gnt_mb%0d", mb[m]), {28'd0, gnt[m]}, own[m] ? 32'd1 << owner[m] : 32'd0);
            check($sformatf("sel_mb%0d", mb[m]), {30'd0, sel[m]}, owner[m]);
            check($sformatf("valid_mb%0d", mb[m]), {31'd0, valid[m]}, {31'd0, own[m] && r[owner[m]]});
            if (own[m]) check($sformatf("cnt_mb%0d", mb[m]), {24'd0, beat_cnt[m]}, cnt[m]);
        end
        @(posedge clk);
        for (int m = 0; m < 3; m++) begin
            if (rs) begin
                own[m] = 0; owner[m] = 0; ptr[m] = 0; cnt[m] = 0;
            end else if (!own[m]) begin
                w = pick(r, ptr[m]);
                if (w >= 0) begin own[m] = 1; owner[m] = w; cnt[m] = 0; end
            end else begin
                bt = r[owner[m]] && rd;
                if (r[owner[m]] && !(bt && cnt[m] == mb[m] - 1)) begin
                    cnt[m] += int'(bt);
                end else begin
                    ptr[m] = (owner[m] + 1) % 4;
                    w = pick(r, ptr[m]);
                    if (w >= 0) begin owner[m] = w; cnt[m] = 0; end
                    else begin own[m] = 0; cnt[m] = 0; end
                end
            end
        end
    endtask

    initial begin
        logic [3:0] r;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", {28'd0, gnt[2]}, 32'd0);
        check("rst_sel", {30'd0, sel[2]}, 32'd0);
        check("rst_valid", {31'd0, valid[2]}, 32'd0);
        check("rst_cnt", {24'd0, beat_cnt[2]}, 32'd0);

        // single requester, continuous re-grant with no idle cycle
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0001, 1'b1, 1'b0);
            #1;
            check("r29_gnt", {28'd0, gnt[2]}, 32'd1);
            check("r29_cnt", {24'd0, beat_cnt[2]}, i % 4);
        end

        // all requesting: rotation with 2 beats (MB2) and 1 beat (MB1) per grant
        cycle(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            #1;
            check("r30_gnt", {28'd0, gnt[1]}, 32'd1 << ((i / 2) % 4));
            check("r30_sel", {30'd0, sel[1]}, (i / 2) % 4);
            check("r30_cnt", {24'd0, beat_cnt[1]}, i % 2);
            check("r34_mux", mux_word[1], 32'h11111111 * ((i / 2) % 4 + 1));
            check("r25_gnt", {28'd0, gnt[0]}, 32'd1 << (i % 4));
        end

        // unlimited stall holds state
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b1, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0);
        repeat (10) cycle(4'b0010, 1'b0, 1'b0);
        #1;
        check("r31_gnt", {28'd0, gnt[2]}, 32'h2);
        check("r31_valid", {31'd0, valid[2]}, 32'd1);
        check("r31_cnt", {24'd0, beat_cnt[2]}, 32'd1);
        cycle(4'b0010, 1'b1, 1'b0);
        #1;
        check("r31_resume", {24'd0, beat_cnt[2]}, 32'd2);

        // owner drops req: immediate handoff, then pointer wraps to 0
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b1100, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0);
        #1;
        check("r32_gnt", {28'd0, gnt[2]}, 32'h8);
        check("r32_sel", {30'd0, sel[2]}, 32'd3);
        check("r32_cnt", {24'd0, beat_cnt[2]}, 32'd0);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0);
        #1;
        check("r32_ptr0", {28'd0, gnt[2]}, 32'h1);

        // reset mid-burst discards the grant
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b1);
        #1;
        check("r33_gnt", {28'd0, gnt[2]}, 32'd0);
        check("r33_sel", {30'd0, sel[2]}, 32'd0);
        check("r33_cnt", {24'd0, beat_cnt[2]}, 32'd0);
        cycle(4'b1010, 1'b1, 1'b0);
        #1;
        check("r33_regrant", {28'd0, gnt[2]}, 32'h2);

        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
